// File: rtl/xy2_pkg.sv
// Shared types, constants and parity helper for the XY2-100 link receiver.
package xy2_pkg;

    localparam int unsigned FRAME_BITS = 20;
    localparam int unsigned DATA_BITS  = 16;
    localparam int unsigned HDR_BITS   = 3;
    localparam int unsigned BITCNT_W   = 5;

    localparam logic [HDR_BITS-1:0] HDR_16B = 3'b001;

    typedef enum logic [1:0] {
        HUNT,
        WAIT1,
        RECV,
        CHECK
    } rx_state_e;

    typedef struct packed {
        logic sync;
        logic clk;
        logic x;
        logic y;
    } link_t;

    // XOR of all bits: 0 means the vector already has even parity
    function automatic logic even_par20(input logic [FRAME_BITS-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/xy2_rx_chan.sv
// One XY2-100 data channel: frame shift register with header/parity qualification.
module xy2_rx_chan
    import xy2_pkg::*;
(
    input  logic                 clk_ref,
    input  logic                 sys_rstn,
    input  logic                 shift_en,
    input  logic                 din,
    output logic [DATA_BITS-1:0] data,
    output logic                 good
);

    logic [FRAME_BITS-1:0] sreg;
    logic [FRAME_BITS-1:0] sreg_n;

    assign sreg_n = {sreg[FRAME_BITS-2:0], din};

    // good is judged on the value being shifted in, so it is ready with the last bit
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sreg <= '0;
            good <= 1'b0;
        end else if (shift_en) begin
            sreg <= sreg_n;
            good <= (sreg_n[FRAME_BITS-1 -: HDR_BITS] == HDR_16B) && !even_par20(sreg_n);
        end
    end

    assign data = sreg[DATA_BITS:1];

endmodule

// File: rtl/xy2_100_rx.sv
// XY2-100 galvo link receiver: synchronisers, frame FSM, link watchdog,
// error counter and the serial status transmitter.
module xy2_100_rx
    import xy2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 200,
    parameter bit          SIGNED_OUT  = 1'b1
) (
    input  logic                 clk_ref,
    input  logic                 sys_rstn,
    input  logic                 xy_sync,
    input  logic                 xy_clk,
    input  logic                 xy_x,
    input  logic                 xy_y,
    output logic                 xy_status,
    input  logic [DATA_BITS-1:0] status_word,
    output logic [DATA_BITS-1:0] pos_x,
    output logic [DATA_BITS-1:0] pos_y,
    output logic                 pos_x_valid,
    output logic                 pos_y_valid,
    output logic                 frame_err_x,
    output logic                 frame_err_y,
    output logic                 link_ok,
    output logic [DATA_BITS-1:0] err_cnt
);

    localparam int unsigned         IDLE_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(FRAME_BITS - 1);
    localparam logic [DATA_BITS-1:0] POS_FLIP = SIGNED_OUT ? 16'h8000 : 16'h0000;

    link_t s1, s2, s3;
    logic  clk_fall_c, clk_rise_c, sync_rise_c;

    // Two-stage synchroniser plus a third stage for edge detection
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= '{sync: xy_sync, clk: xy_clk, x: xy_x, y: xy_y};
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign clk_fall_c  =  s3.clk & ~s2.clk;
    assign clk_rise_c  = ~s3.clk &  s2.clk;
    assign sync_rise_c =  s2.sync & ~s3.sync;

    logic [IDLE_W-1:0] idle_cnt;
    logic              timeout_c;

    assign timeout_c = !(clk_fall_c || clk_rise_c) && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            idle_cnt <= '0;
        end else if (clk_fall_c || clk_rise_c || timeout_c) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    rx_state_e           state, state_n;
    logic [BITCNT_W-1:0] bitcnt, bitcnt_n;
    logic                shift_c, check_c, frame_bad_c;

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state  <= HUNT;
            bitcnt <= '0;
        end else begin
            state  <= state_n;
            bitcnt <= bitcnt_n;
        end
    end

    // Data and sync are taken from the stage aligned with the detected falling edge
    always_comb begin
        state_n     = state;
        bitcnt_n    = bitcnt;
        shift_c     = 1'b0;
        check_c     = 1'b0;
        frame_bad_c = 1'b0;
        case (state)
            HUNT: begin
                if (clk_fall_c && !s3.sync) state_n = WAIT1;
            end
            WAIT1: begin
                if (clk_fall_c && s3.sync) begin
                    shift_c  = 1'b1;
                    bitcnt_n = BITCNT_W'(1);
                    state_n  = RECV;
                end
            end
            RECV: begin
                if (clk_fall_c) begin
                    shift_c  = 1'b1;
                    bitcnt_n = bitcnt + BITCNT_W'(1);
                    if (!s3.sync) begin
                        if (bitcnt == LAST_BIT) begin
                            state_n = CHECK;
                        end else begin
                            frame_bad_c = 1'b1;
                            state_n     = WAIT1;
                        end
                    end else if (bitcnt == LAST_BIT) begin
                        frame_bad_c = 1'b1;
                        state_n     = HUNT;
                    end
                end
            end
            CHECK: begin
                check_c = 1'b1;
                state_n = WAIT1;
            end
            default: state_n = HUNT;
        endcase
        if (timeout_c) state_n = HUNT;
    end

    logic [DATA_BITS-1:0] data_x, data_y;
    logic                 good_x, good_y;

    xy2_rx_chan u_chan_x (
        .clk_ref  (clk_ref),
        .sys_rstn (sys_rstn),
        .shift_en (shift_c),
        .din      (s3.x),
        .data     (data_x),
        .good     (good_x)
    );

    xy2_rx_chan u_chan_y (
        .clk_ref  (clk_ref),
        .sys_rstn (sys_rstn),
        .shift_en (shift_c),
        .din      (s3.y),
        .data     (data_y),
        .good     (good_y)
    );

    // Setpoints, per-channel pulses, link health and the bad-frame counter
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            pos_x       <= '0;
            pos_y       <= '0;
            pos_x_valid <= 1'b0;
            pos_y_valid <= 1'b0;
            frame_err_x <= 1'b0;
            frame_err_y <= 1'b0;
            link_ok     <= 1'b0;
            err_cnt     <= '0;
        end else begin
            pos_x_valid <= 1'b0;
            pos_y_valid <= 1'b0;
            frame_err_x <= 1'b0;
            frame_err_y <= 1'b0;
            if (check_c) begin
                if (good_x) begin
                    pos_x       <= data_x ^ POS_FLIP;
                    pos_x_valid <= 1'b1;
                end else begin
                    frame_err_x <= 1'b1;
                end
                if (good_y) begin
                    pos_y       <= data_y ^ POS_FLIP;
                    pos_y_valid <= 1'b1;
                end else begin
                    frame_err_y <= 1'b1;
                end
                if (good_x && good_y) link_ok <= 1'b1;
            end
            if (timeout_c) link_ok <= 1'b0;
            if ((frame_bad_c || (check_c && !(good_x && good_y))) && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    logic [FRAME_BITS-1:0] tx_sreg;

    // Status word goes out MSB first; zeros fill behind so the line idles low
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            tx_sreg <= '0;
        end else if (timeout_c) begin
            tx_sreg <= '0;
        end else if (sync_rise_c) begin
            tx_sreg <= {HDR_16B, status_word, even_par20({HDR_16B, status_word, 1'b0})};
        end else if (clk_rise_c) begin
            tx_sreg <= {tx_sreg[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign xy_status = tx_sreg[FRAME_BITS-1];

endmodule

// File: tb/tb_xy2_100_rx.sv
// Self-checking bench for xy2_100_rx: drives XY2-100 frames and compares against a frame-level model.
module tb_xy2_100_rx;

    logic        clk_ref     = 1'b0;
    logic        sys_rstn    = 1'b0;
    logic        xy_sync     = 1'b0;
    logic        xy_clk      = 1'b0;
    logic        xy_x        = 1'b0;
    logic        xy_y        = 1'b0;
    logic        xy_status;
    logic [15:0] status_word = 16'h0000;
    logic [15:0] pos_x, pos_y, err_cnt;
    logic        pos_x_valid, pos_y_valid, frame_err_x, frame_err_y, link_ok;

    xy2_100_rx #(.TIMEOUT_CYC(200), .SIGNED_OUT(1'b1)) dut (
        .clk_ref     (clk_ref),
        .sys_rstn    (sys_rstn),
        .xy_sync     (xy_sync),
        .xy_clk      (xy_clk),
        .xy_x        (xy_x),
        .xy_y        (xy_y),
        .xy_status   (xy_status),
        .status_word (status_word),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .pos_x_valid (pos_x_valid),
        .pos_y_valid (pos_y_valid),
        .frame_err_x (frame_err_x),
        .frame_err_y (frame_err_y),
        .link_ok     (link_ok),
        .err_cnt     (err_cnt)
    );

    always #5 clk_ref = ~clk_ref;

    int n_checks = 0;
    int n_fail   = 0;

    // Cycles each pulse is seen high; a stretched pulse shows up as an extra count
    int vx_cnt = 0, vy_cnt = 0, ex_cnt = 0, ey_cnt = 0;
    always @(negedge clk_ref) begin
        if (pos_x_valid) vx_cnt++;
        if (pos_y_valid) vy_cnt++;
        if (frame_err_x) ex_cnt++;
        if (frame_err_y) ey_cnt++;
    end

    // Reference model state, kept per frame
    bit          aligned = 1'b0;
    bit          prev_sync = 1'b0;
    bit          m_link = 1'b0;
    logic [15:0] m_px = '0, m_py = '0, m_err = '0;
    logic [19:0] last_cap = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] build(input logic [15:0] d);
        logic [18:0] hd;
        hd = {3'b001, d};
        return {hd, 1'($countones(hd) % 2)};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [19:0] pick_mask(input int sel, input int pos);
        logic [19:0] one;
        one = 20'h1;
        case (sel)
            5:       return 20'h00001;
            6:       return 20'h20002;
            7:       return one << pos;
            default: return 20'h00000;
        endcase
    endfunction

    task automatic bit_slot(input bit s, input bit dx, input bit dy, input bit do_rst, output bit samp);
        xy_sync = s;
        xy_x    = dx;
        xy_y    = dy;
        xy_clk  = 1'b1;
        if (do_rst) begin
            repeat (2) @(negedge clk_ref);
            sys_rstn = 1'b0;
            @(negedge clk_ref);
            check("rst_pos_x", 32'(pos_x), 32'h0);
            check("rst_pos_y", 32'(pos_y), 32'h0);
            check("rst_link_ok", 32'(link_ok), 32'h0);
            check("rst_err_cnt", 32'(err_cnt), 32'h0);
            check("rst_xy_status", 32'(xy_status), 32'h0);
            check("rst_pulses", 32'({pos_x_valid, pos_y_valid, frame_err_x, frame_err_y}), 32'h0);
            sys_rstn = 1'b1;
            repeat (2) @(negedge clk_ref);
        end else begin
            repeat (5) @(negedge clk_ref);
        end
        samp   = xy_status;
        xy_clk = 1'b0;
        repeat (5) @(negedge clk_ref);
    endtask

    // drop_at > 0 ends the frame early with sync low at that bit; long_frm keeps sync high on the parity slot
    task automatic send_frame(input logic [15:0] dx, input logic [15:0] dy, input logic [15:0] sw,
                              input logic [19:0] mx, input logic [19:0] my,
                              input int drop_at, input bit long_frm, input int rst_at);
        logic [19:0] fx, fy, cap;
        bit          s, samp, tx_chk, gx, gy;
        int          b0, vx0, vy0, ex0, ey0, evx, evy, eex, eey;
        fx          = build(dx) ^ mx;
        fy          = build(dy) ^ my;
        status_word = sw;
        tx_chk      = !prev_sync && (rst_at < 0) && (drop_at <= 0);
        vx0 = vx_cnt; vy0 = vy_cnt; ex0 = ex_cnt; ey0 = ey_cnt;
        evx = 0; evy = 0; eex = 0; eey = 0;
        cap = '0;
        b0  = (drop_at > 0) ? drop_at : 0;
        for (int i = 19; i >= b0; i--) begin
            s = (i != b0) || long_frm;
            bit_slot(s, fx[i], fy[i], i == rst_at, samp);
            cap       = {cap[18:0], samp};
            prev_sync = s;
        end
        last_cap = cap;
        repeat (3) @(negedge clk_ref);

        if (rst_at >= 0) begin
            m_px = '0; m_py = '0; m_err = '0; m_link = 1'b0;
            aligned = !long_frm;
        end else if (!aligned) begin
            aligned = !long_frm;
        end else if (drop_at > 0) begin
            m_err = sat_inc(m_err);
        end else if (long_frm) begin
            m_err   = sat_inc(m_err);
            aligned = 1'b0;
        end else begin
            gx = (fx[19:17] == 3'b001) && (($countones(fx) % 2) == 0);
            gy = (fy[19:17] == 3'b001) && (($countones(fy) % 2) == 0);
            if (gx) begin m_px = fx[16:1] ^ 16'h8000; evx = 1; end else eex = 1;
            if (gy) begin m_py = fy[16:1] ^ 16'h8000; evy = 1; end else eey = 1;
            if (gx && gy) m_link = 1'b1;
            else          m_err  = sat_inc(m_err);
        end

        check("pos_x", 32'(pos_x), 32'(m_px));
        check("pos_y", 32'(pos_y), 32'(m_py));
        check("valid_x_cycles", 32'(vx_cnt - vx0), 32'(evx));
        check("valid_y_cycles", 32'(vy_cnt - vy0), 32'(evy));
        check("err_x_cycles", 32'(ex_cnt - ex0), 32'(eex));
        check("err_y_cycles", 32'(ey_cnt - ey0), 32'(eey));
        check("link_ok", 32'(link_ok), 32'(m_link));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
        if (tx_chk) check("status_tx", 32'(cap), 32'(build(sw)));
    endtask

    initial begin
        int vx0, vy0;
        repeat (3) @(negedge clk_ref);
        check("reset_pos_x", 32'(pos_x), 32'h0);
        check("reset_pos_y", 32'(pos_y), 32'h0);
        check("reset_link_ok", 32'(link_ok), 32'h0);
        check("reset_err_cnt", 32'(err_cnt), 32'h0);
        check("reset_xy_status", 32'(xy_status), 32'h0);
        sys_rstn = 1'b1;
        @(negedge clk_ref);

        // First frame only provides the parity slot the receiver hunts for
        send_frame(16'h4444, 16'h5555, 16'h0F0F, '0, '0, -1, 1'b0, -1);
        send_frame(16'h1234, 16'hABCD, 16'h5A5A, '0, '0, -1, 1'b0, -1);
        check("known_pos_x", 32'(pos_x), 32'h9234);
        check("known_pos_y", 32'(pos_y), 32'h2BCD);
        check("known_status", 32'(last_cap), 32'h2B4B5);

        send_frame(16'h0F0F, 16'h7777, 16'h1357, 20'h00001, '0, -1, 1'b0, -1);
        check("parity_x_hold", 32'(pos_x), 32'h9234);
        check("parity_x_errcnt", 32'(err_cnt), 32'h1);

        send_frame(16'h2222, 16'h3333, 16'h2468, '0, 20'h20002, -1, 1'b0, -1);
        send_frame(16'h6666, 16'h7777, 16'h0000, '0, '0, 10, 1'b0, -1);
        send_frame(16'h8001, 16'h7FFE, 16'hFFFF, '0, '0, -1, 1'b0, -1);
        send_frame(16'h9999, 16'hAAAA, 16'h1111, '0, '0, -1, 1'b1, -1);
        send_frame(16'hBBBB, 16'hCCCC, 16'h2222, '0, '0, -1, 1'b0, -1);
        send_frame(16'hDDDD, 16'hEEEE, 16'h3333, '0, '0, -1, 1'b0, -1);

        // Link clock stops for 250 cycles
        vx0 = vx_cnt; vy0 = vy_cnt;
        repeat (180) @(negedge clk_ref);
        check("link_before_timeout", 32'(link_ok), 32'h1);
        repeat (40) @(negedge clk_ref);
        check("link_after_timeout", 32'(link_ok), 32'h0);
        check("timeout_hold_x", 32'(pos_x), 32'(m_px));
        check("timeout_hold_y", 32'(pos_y), 32'(m_py));
        check("timeout_status", 32'(xy_status), 32'h0);
        repeat (30) @(negedge clk_ref);
        check("timeout_no_valid", 32'((vx_cnt - vx0) + (vy_cnt - vy0)), 32'h0);
        m_link  = 1'b0;
        aligned = 1'b0;
        send_frame(16'h0102, 16'h0304, 16'h4321, '0, '0, -1, 1'b0, -1);
        send_frame(16'h0506, 16'h0708, 16'h8765, '0, '0, -1, 1'b0, -1);

        send_frame(16'hCAFE, 16'hBEEF, 16'h1122, '0, '0, -1, 1'b0, 8);
        send_frame(16'hFACE, 16'hD00D, 16'h3344, '0, '0, -1, 1'b0, -1);

        for (int k = 0; k < 12; k++) begin
            logic [19:0] mx, my;
            int          dr;
            mx = pick_mask(int'($urandom_range(0, 7)), int'($urandom_range(0, 19)));
            my = pick_mask(int'($urandom_range(0, 7)), int'($urandom_range(0, 19)));
            dr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 18)) : -1;
            send_frame(16'($urandom), 16'($urandom), 16'($urandom), mx, my, dr, 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
